// File: rtl/board_uart_tx.sv
// rtl/board_uart_tx.sv - serialises a snapshot of a 3x3 game board as a 12-byte 8N1 UART frame
// Frame: nine cell characters, a winner character, then CR LF; tx is always a registered output.
module board_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] winner,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [3:0]        LAST_BYTE = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START_BIT = 2'd1,
    S_DATA_BITS = 2'd2,
    S_STOP_BIT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [19:0]       snap_q, snap_d;

  logic [19:0]       snap_in;
  logic [7:0]        cur_byte;
  logic              baud_wrap;

  function automatic logic [7:0] cell_char(input logic [1:0] c);
    case (c)
      2'b00:   cell_char = 8'h2E;
      2'b01:   cell_char = 8'h58;
      2'b10:   cell_char = 8'h4F;
      default: cell_char = 8'h3F;
    endcase
  endfunction

  function automatic logic [7:0] win_char(input logic [1:0] w);
    case (w)
      2'b00:   win_char = 8'h2D;
      2'b01:   win_char = 8'h31;
      2'b10:   win_char = 8'h32;
      default: win_char = 8'h44;
    endcase
  endfunction

  assign snap_in   = {winner, pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  assign baud_wrap = (baud_q == BAUD_LAST);

  // Byte currently on the wire, looked up from the frozen snapshot.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx_q)
      4'd0:    cur_byte = cell_char(snap_q[1:0]);
      4'd1:    cur_byte = cell_char(snap_q[3:2]);
      4'd2:    cur_byte = cell_char(snap_q[5:4]);
      4'd3:    cur_byte = cell_char(snap_q[7:6]);
      4'd4:    cur_byte = cell_char(snap_q[9:8]);
      4'd5:    cur_byte = cell_char(snap_q[11:10]);
      4'd6:    cur_byte = cell_char(snap_q[13:12]);
      4'd7:    cur_byte = cell_char(snap_q[15:14]);
      4'd8:    cur_byte = cell_char(snap_q[17:16]);
      4'd9:    cur_byte = win_char(snap_q[19:18]);
      4'd10:   cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    baud_d     = baud_q;
    snap_d     = snap_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d    = S_START_BIT;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          byte_idx_d = 4'd0;
          bit_cnt_d  = 3'd0;
          baud_d     = '0;
          snap_d     = snap_in;
        end
      end

      S_START_BIT: begin
        if (baud_wrap) begin
          baud_d    = '0;
          state_d   = S_DATA_BITS;
          bit_cnt_d = 3'd0;
          tx_d      = cur_byte[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_DATA_BITS: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = cur_byte[bit_cnt_d];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_STOP_BIT: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (byte_idx_q == LAST_BYTE) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = S_START_BIT;
            tx_d       = 1'b0;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_idx_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      baud_q     <= '0;
      snap_q     <= 20'd0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_q     <= baud_d;
      snap_q     <= snap_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_board_uart_tx.sv
// tb/tb_board_uart_tx.sv - self-checking bench for board_uart_tx with CLKS_PER_BIT=4
// A frame-level model predicts tx/busy/done every cycle; a bench UART receiver decodes bytes.
module tb_board_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 120 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] pos [1:9];
  logic [1:0] winner = 2'b00;
  logic       tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  board_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .pos1(pos[1]), .pos2(pos[2]), .pos3(pos[3]), .pos4(pos[4]), .pos5(pos[5]),
    .pos6(pos[6]), .pos7(pos[7]), .pos8(pos[8]), .pos9(pos[9]),
    .winner(winner), .tx(tx), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cell_chr(input logic [1:0] c);
    case (c)
      2'b00: return 8'h2E;
      2'b01: return 8'h58;
      2'b10: return 8'h4F;
      default: return 8'h3F;
    endcase
  endfunction

  function automatic logic [7:0] win_chr(input logic [1:0] w);
    case (w)
      2'b00: return 8'h2D;
      2'b01: return 8'h31;
      2'b10: return 8'h32;
      default: return 8'h44;
    endcase
  endfunction

  // Model: a frame is a timeline of 480 cycles; bit slot s of byte k is start/data/stop.
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_bytes [12];

  function automatic logic exp_tx(input int t);
    int k, slot;
    k    = t / (10 * CPB);
    slot = (t % (10 * CPB)) / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_bytes[k][slot-1];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_t == FRAME - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_t      <= 0;
        for (int k = 0; k < 9; k++) m_bytes[k] <= cell_chr(pos[k+1]);
        m_bytes[9]  <= win_chr(winner);
        m_bytes[10] <= 8'h0D;
        m_bytes[11] <= 8'h0A;
      end
    end
  end

  always @(negedge clk) begin
    chk("tx_model", tx, m_active ? exp_tx(m_t) : 1'b1);
    chk("busy_model", busy, m_active);
    chk("done_model", done, m_done);
  end

  // Bench UART receiver sampling mid-bit.
  logic [7:0] rx_q [$];
  logic [7:0] rx_sh = 8'h00;
  bit         rx_busy = 1'b0;
  int         rx_ph = 0;
  int         rx_err = 0;

  always @(negedge clk) begin
    if (!reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_ph   = 0;
      end
    end else begin
      rx_ph++;
      for (int i = 0; i < 8; i++)
        if (rx_ph == CPB * (i + 1) + CPB / 2) rx_sh[i] = tx;
      if (rx_ph == 9 * CPB + CPB / 2) begin
        if (tx) rx_q.push_back(rx_sh);
        else rx_err++;
        rx_busy = 1'b0;
      end
    end
  end

  task automatic set_board(input logic [17:0] b, input logic [1:0] w);
    for (int i = 1; i <= 9; i++) pos[i] = b[2*(i-1) +: 2];
    winner = w;
  endtask

  // Returns at the negedge of cycle 0 of the accepted frame.
  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int t_start, output int t_done, output int busy_n, output int run);
    int t;
    t = t_start;
    busy_n = 0;
    run = 0;
    while (!done && t < t_start + 4 * FRAME) begin
      if (busy) busy_n++;
      run = tx ? run + 1 : 0;
      @(negedge clk);
      t++;
    end
    run = tx ? run + 1 : 0;
    chk("done_seen", done, 1'b1);
    t_done = t;
  endtask

  task automatic check_bytes(input string name, input string exp_s, input int base);
    logic [31:0] act;
    for (int k = 0; k < exp_s.len(); k++) begin
      act = (base + k < rx_q.size()) ? {24'd0, rx_q[base + k]} : 32'hFFFF;
      chk(name, act, {24'd0, exp_s[k]});
    end
  endtask

  int exp_b0 [8] = '{0, 0, 0, 1, 1, 0, 1, 0};

  initial begin
    int t_done, busy_n, run;
    for (int i = 1; i <= 9; i++) pos[i] = 2'b00;
    #1 reset = 1'b0;
    start = 1'b1;

    // Reset held with start high.
    repeat (4) begin
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("accept_after_release_busy", busy, 1'b1);
    chk("accept_after_release_tx", tx, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rx_q.delete();

    // Empty board.
    set_board(18'd0, 2'b00);
    start_frame();
    wait_done(0, t_done, busy_n, run);
    chk("empty_done_cycle", t_done, FRAME);
    chk("empty_busy_cycles", busy_n, FRAME);
    @(negedge clk);
    chk("empty_done_single", done, 1'b0);
    chk("empty_rx_count", rx_q.size(), 12);
    check_bytes("empty_byte", ".........-\r\n", 0);
    rx_q.delete();

    // Mixed board, first-byte bit timing.
    set_board(18'b01_00_00_00_01_00_10_10_01, 2'b01);
    start_frame();
    chk("mix_start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      chk("mix_first_byte_bit", tx, exp_b0[i]);
    end
    wait_done(CPB * 8, t_done, busy_n, run);
    chk("mix_done_cycle", t_done, FRAME);
    repeat (3) @(negedge clk);
    chk("mix_rx_count", rx_q.size(), 12);
    check_bytes("mix_byte", "XOO.X...X1\r\n", 0);
    rx_q.delete();

    // Snapshot and ignored starts during busy, including the done edge.
    set_board(18'd0, 2'b00);
    start_frame();
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (c == 50) set_board(18'h15555, 2'b11);
      if (c == 200) start = 1'b1;
      if (c == 201) start = 1'b0;
      if (c == FRAME - 1) start = 1'b1;
      if (c == FRAME) begin
        start = 1'b0;
        chk("snap_done", done, 1'b1);
      end
    end
    repeat (20) @(negedge clk);
    chk("snap_no_extra_busy", busy, 1'b0);
    chk("snap_rx_count", rx_q.size(), 12);
    check_bytes("snap_byte", ".........-\r\n", 0);
    rx_q.delete();

    // start held high for two back-to-back frames.
    set_board(18'd0, 2'b00);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(0, t_done, busy_n, run);
    chk("held_done_cycle", t_done, FRAME);
    chk("held_gap_ones", run, CPB + 1);
    @(negedge clk);
    chk("held_second_tx", tx, 1'b0);
    chk("held_second_busy", busy, 1'b1);
    start = 1'b0;
    wait_done(0, t_done, busy_n, run);
    chk("held2_done_cycle", t_done, FRAME);
    chk("held2_busy_cycles", busy_n, FRAME);
    repeat (3) @(negedge clk);
    chk("held_rx_count", rx_q.size(), 24);
    check_bytes("held1_byte", ".........-\r\n", 0);
    check_bytes("held2_byte", ".........-\r\n", 12);
    rx_q.delete();

    // Reset mid-frame aborts; next frame is clean.
    set_board(18'b10_10_10_10_10_10_10_10_11, 2'b10);
    start_frame();
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("abort_quiet_tx", tx, 1'b1);
      chk("abort_quiet_busy", busy, 1'b0);
    end
    rx_q.delete();
    set_board(18'b00_00_00_00_11_00_00_00_00, 2'b11);
    start_frame();
    wait_done(0, t_done, busy_n, run);
    chk("after_abort_done_cycle", t_done, FRAME);
    repeat (3) @(negedge clk);
    chk("after_abort_rx_count", rx_q.size(), 12);
    check_bytes("after_abort_byte", "....?....D\r\n", 0);
    chk("rx_framing_errors", rx_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
